ram_b_port_arbiter: RTL and testbench

Shares port B of the data-memory dual-port RAM between two masters, requester 0 and requester 1, such as a display scanner and a debug/loader engine, while the processor keeps exclusive use of port A. Each cycle the block arbitrates round-robin and drives the RAM port-B address, data and write-enable from the winner. It tags every granted read and routes the returned data, with a valid strobe, back to the requester that issued it after the RAM's fixed read latency. It sits beside the processor and RAM at top level and replaces the constant port-B tie-offs.

---
 rtl/ram_b_pkg.sv | 14 +
 rtl/rd_tag_pipe.sv | 30 +++
 rtl/ram_b_port_arbiter.sv | 94 +++++++++
 tb/tb_ram_b_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_b_pkg.sv
// Shared types for the RAM port-B arbiter: default widths and the read-return tag.
package ram_b_pkg;

  localparam int AW_DEF = 11;
  localparam int DW_DEF = 8;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags; the head lines up with the RAM's read data.
module rd_tag_pipe
  import ram_b_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic    clk,
  input  logic    clear,
  input  rd_tag_t tag_in,
  output rd_tag_t head
);

  rd_tag_t stages [RD_LAT];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign head = stages[RD_LAT-1];

endmodule

// File: rtl/ram_b_port_arbiter.sv
// Round-robin arbiter sharing RAM port B between two requesters, with tagged read-data return.
module ram_b_port_arbiter
  import ram_b_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  logic    last_winner;
  rd_tag_t tag_in;
  rd_tag_t head;

  // Grants are suppressed while reset is held so nothing reaches the RAM.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (last_winner) gnt0 = 1'b1;
        else             gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (gnt0) begin
      ram_addr  = addr0;
      ram_wdata = wdata0;
      ram_we    = we0;
    end else if (gnt1) begin
      ram_addr  = addr1;
      ram_wdata = wdata1;
      ram_we    = we1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner <= 1'b1;
    end else if (gnt0) begin
      last_winner <= 1'b0;
    end else if (gnt1) begin
      last_winner <= 1'b1;
    end
  end

  always_comb begin
    tag_in.valid = (gnt0 && !we0) || (gnt1 && !we1);
    tag_in.id    = gnt1;
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk    (clk),
    .clear  (reset),
    .tag_in (tag_in),
    .head   (head)
  );

  // The head tag is still live during the reset cycle itself, so gate it here.
  assign rvalid0 = !reset && head.valid && (head.id == 1'b0);
  assign rvalid1 = !reset && head.valid && (head.id == 1'b1);
  assign rdata   = ram_q;

endmodule

// File: tb/tb_ram_b_port_arbiter.sv
// Table-driven bench for ram_b_port_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_ram_b_port_arbiter;

  localparam int AW     = 11;
  localparam int DW     = 8;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << AW;

  typedef struct {
    logic          rst;
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          g0;
    logic          g1;
  } vec_t;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } exp_rd_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  logic          preload;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] qp [RD_LAT];
  logic [DW-1:0] ref_mem [DEPTH];

  exp_rd_t sb [$];
  vec_t    vecs [$];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;

  ram_b_port_arbiter #(
    .AW     (AW),
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 5) return 8'hA5;
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Behavioural RAM: read data appears RD_LAT edges after the address is captured.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    qp[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
  end
  assign ram_q = qp[RD_LAT-1];

  function automatic vec_t mk(logic rst, logic r0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                              logic r1, logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                              logic g0, logic g1);
    vec_t v;
    v.rst = rst; v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1; v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
  endfunction

  function automatic vec_t rst_v();
    return mk(1, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drives one cycle, checks combinational and returned-read outputs, then advances the models.
  task automatic apply_stimulus(input vec_t v);
    logic          e0, e1;
    logic [DW-1:0] ed;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic          ewe;
    reset = v.rst;
    req0 = v.req0; we0 = v.we0; addr0 = v.addr0; wdata0 = v.wdata0;
    req1 = v.req1; we1 = v.we1; addr1 = v.addr1; wdata1 = v.wdata1;
    if (v.rst) sb.delete();
    @(negedge clk);
    check_output("gnt0", 32'(gnt0), 32'(v.g0));
    check_output("gnt1", 32'(gnt1), 32'(v.g1));
    ea = v.g0 ? v.addr0 : (v.g1 ? v.addr1 : '0);
    ew = v.g0 ? v.wdata0 : (v.g1 ? v.wdata1 : '0);
    ewe = v.g0 ? v.we0 : (v.g1 ? v.we1 : 1'b0);
    check_output("ram_addr", 32'(ram_addr), 32'(ea));
    check_output("ram_wdata", 32'(ram_wdata), 32'(ew));
    check_output("ram_we", 32'(ram_we), 32'(ewe));
    e0 = 1'b0; e1 = 1'b0; ed = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      if (sb[0].id) e1 = 1'b1;
      else          e0 = 1'b1;
      ed = sb[0].data;
      void'(sb.pop_front());
    end
    check_output("rvalid0", 32'(rvalid0), 32'(e0));
    check_output("rvalid1", 32'(rvalid1), 32'(e1));
    if (e0 || e1) check_output("rdata", 32'(rdata), 32'(ed));
    if (v.g0) begin
      if (v.we0) ref_mem[v.addr0] = v.wdata0;
      else sb.push_back('{id: 1'b0, data: ref_mem[v.addr0], due: cyc + RD_LAT});
    end
    if (v.g1) begin
      if (v.we1) ref_mem[v.addr1] = v.wdata1;
      else sb.push_back('{id: 1'b1, data: ref_mem[v.addr1], due: cyc + RD_LAT});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;

    vecs.push_back(rst_v());
    vecs.push_back(rst_v());
    // Single read of the preloaded 0xA5
    vecs.push_back(mk(0, 1, 0, 11'h005, 8'h00, 0, 0, '0, '0, 1, 0));
    repeat (3) vecs.push_back(idle());
    // Contention straight after reset alternates starting with requester 0
    vecs.push_back(rst_v());
    vecs.push_back(mk(0, 1, 0, 11'h010, 8'h00, 1, 0, 11'h020, 8'h00, 1, 0));
    vecs.push_back(mk(0, 1, 0, 11'h010, 8'h00, 1, 0, 11'h020, 8'h00, 0, 1));
    vecs.push_back(mk(0, 1, 0, 11'h010, 8'h00, 1, 0, 11'h020, 8'h00, 1, 0));
    vecs.push_back(mk(0, 1, 0, 11'h010, 8'h00, 1, 0, 11'h020, 8'h00, 0, 1));
    repeat (2) vecs.push_back(idle());
    // Write then read at the top address
    vecs.push_back(mk(0, 0, 0, '0, '0, 1, 1, 11'h7FF, 8'h3C, 0, 1));
    vecs.push_back(mk(0, 0, 0, '0, '0, 1, 0, 11'h7FF, 8'h00, 0, 1));
    repeat (3) vecs.push_back(idle());
    // Streaming reads by requester 0
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 0, 11'(i), 8'h00, 0, 0, '0, '0, 1, 0));
    repeat (3) vecs.push_back(idle());

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Reset mid-flight: both in-flight reads vanish, fairness restarts at requester 0
    apply_stimulus(mk(0, 0, 0, '0, '0, 1, 0, 11'h020, 8'h00, 0, 1));
    apply_stimulus(mk(0, 1, 0, 11'h010, 8'h00, 0, 0, '0, '0, 1, 0));
    apply_stimulus(rst_v());
    apply_stimulus(idle());
    apply_stimulus(idle());
    apply_stimulus(mk(0, 1, 0, 11'h010, 8'h00, 1, 0, 11'h020, 8'h00, 1, 0));
    repeat (3) apply_stimulus(idle());

    // Read-before-write then write-then-read on a shared address
    apply_stimulus(mk(0, 1, 1, 11'h100, 8'h55, 1, 0, 11'h100, 8'h00, 0, 1));
    apply_stimulus(mk(0, 1, 1, 11'h100, 8'h55, 0, 0, '0, '0, 1, 0));
    apply_stimulus(mk(0, 0, 0, '0, '0, 1, 0, 11'h100, 8'h00, 0, 1));
    repeat (3) apply_stimulus(idle());

    // Idle stretch
    repeat (5) apply_stimulus(idle());

    check_output("drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
